// File: rtl/snake_control.sv
// Snake game controller: segment shift register, direction/step logic, target and collision checks.
// Optional macro SNAKE_WRAP_EN makes the head wrap at grid edges instead of ending the game.
module snake_control #(
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned INIT_LEN = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       MOVE_TICK,
  input  logic       GAME_RUN,
  input  logic [1:0] DIR_IN,
  input  logic [7:0] TARGET_ADDR_H,
  input  logic [6:0] TARGET_ADDR_V,
  input  logic [7:0] ADDR_H,
  input  logic [6:0] ADDR_V,
  output logic       IS_SNAKE,
  output logic       TARGET_REACHED,
  output logic [7:0] HEAD_H,
  output logic [6:0] HEAD_V,
  output logic [5:0] LENGTH,
  output logic       GAME_OVER
);

  localparam int unsigned HW    = 8;
  localparam int unsigned VW    = 7;
  localparam int unsigned LW    = 6;
  localparam int unsigned H_MAX = 159;
  localparam int unsigned V_MAX = 119;

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_OVER
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [HW-1:0]   r_seg_h [MAX_LEN];
  logic [VW-1:0]   r_seg_v [MAX_LEN];
  logic [1:0]      r_dir;
  logic [LW-1:0]   r_len;
  logic            r_wall;
  logic            r_target_reached;
  logic            r_game_over;
  logic            r_is_snake;

  logic [1:0]      w_dir;
  logic [HW-1:0]   w_next_h;
  logic [VW-1:0]   w_next_v;
  logic            w_wall;
  logic            w_move;
  logic            w_self;
  logic            w_target;
  logic            w_query;
  logic            w_tr_nxt;
  logic            w_go_nxt;
  logic            w_grow;

  assign HEAD_H         = r_seg_h[0];
  assign HEAD_V         = r_seg_v[0];
  assign LENGTH         = r_len;
  assign IS_SNAKE       = r_is_snake;
  assign TARGET_REACHED = r_target_reached;
  assign GAME_OVER      = r_game_over;

  assign w_move = MOVE_TICK && GAME_RUN && !r_game_over && (r_state == S_IDLE);

  // Direction filter (reversal discarded) and next-head computation
  always_comb begin
    w_dir    = ((DIR_IN ^ 2'b10) == r_dir) ? r_dir : DIR_IN;
    w_next_h = r_seg_h[0];
    w_next_v = r_seg_v[0];
    w_wall   = 1'b0;
    case (w_dir)
      DIR_UP: begin
        if (r_seg_v[0] == VW'(0)) begin
          if (WRAP) w_next_v = VW'(V_MAX);
          else      w_wall   = 1'b1;
        end else begin
          w_next_v = r_seg_v[0] - VW'(1);
        end
      end
      DIR_DOWN: begin
        if (r_seg_v[0] == VW'(V_MAX)) begin
          if (WRAP) w_next_v = VW'(0);
          else      w_wall   = 1'b1;
        end else begin
          w_next_v = r_seg_v[0] + VW'(1);
        end
      end
      DIR_LEFT: begin
        if (r_seg_h[0] == HW'(0)) begin
          if (WRAP) w_next_h = HW'(H_MAX);
          else      w_wall   = 1'b1;
        end else begin
          w_next_h = r_seg_h[0] - HW'(1);
        end
      end
      default: begin
        if (r_seg_h[0] == HW'(H_MAX)) begin
          if (WRAP) w_next_h = HW'(0);
          else      w_wall   = 1'b1;
        end else begin
          w_next_h = r_seg_h[0] + HW'(1);
        end
      end
    endcase
  end

  // Body match against the head (live body only) and against the display query
  always_comb begin
    w_self   = 1'b0;
    w_query  = 1'b0;
    w_target = (r_seg_h[0] == TARGET_ADDR_H) && (r_seg_v[0] == TARGET_ADDR_V);
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < r_len) begin
        if ((i != 0) && (r_seg_h[i] == r_seg_h[0]) && (r_seg_v[i] == r_seg_v[0]))
          w_self = 1'b1;
        if ((r_seg_h[i] == ADDR_H) && (r_seg_v[i] == ADDR_V))
          w_query = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Post-move check: wall/self collision wins over a target hit
  always_comb begin
    w_state_nxt = r_state;
    w_tr_nxt    = 1'b0;
    w_go_nxt    = r_game_over;
    w_grow      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_move) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (r_wall || w_self) begin
          w_go_nxt    = 1'b1;
          w_state_nxt = S_OVER;
        end else begin
          w_state_nxt = S_IDLE;
          if (w_target) begin
            w_tr_nxt = 1'b1;
            w_grow   = 1'b1;
          end
        end
      end
      S_OVER: begin
        w_go_nxt = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          r_seg_h[i] <= HW'(20 - i);
          r_seg_v[i] <= VW'(60);
        end else begin
          r_seg_h[i] <= '0;
          r_seg_v[i] <= '0;
        end
      end
      r_dir            <= DIR_RIGHT;
      r_len            <= LW'(INIT_LEN);
      r_wall           <= 1'b0;
      r_target_reached <= 1'b0;
      r_game_over      <= 1'b0;
      r_is_snake       <= 1'b0;
    end else begin
      r_target_reached <= w_tr_nxt;
      r_game_over      <= w_go_nxt;
      r_is_snake       <= w_query;
      if (w_move) begin
        r_dir  <= w_dir;
        r_wall <= w_wall;
        if (!w_wall) begin
          for (int i = 1; i < MAX_LEN; i++) begin
            r_seg_h[i] <= r_seg_h[i-1];
            r_seg_v[i] <= r_seg_v[i-1];
          end
          r_seg_h[0] <= w_next_h;
          r_seg_v[0] <= w_next_v;
        end
      end
      if (w_grow && (r_len != LW'(MAX_LEN)))
        r_len <= r_len + LW'(1);
    end
  end

endmodule
